psum_collector: RTL and testbench
=================================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter PSUM_WIDTH, default 16, is the width of the signed partial sum from the PE column.
REQ-002 Parameter ACC_WIDTH, default 24, is the width of each signed accumulator entry.
REQ-003 Parameter OFM_WIDTH, default 8, is the width of the signed output feature-map value.
REQ-004 Parameter DEPTH, default 16, is the number of accumulator entries (output pixels per pass).
REQ-005 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port cfg_start, input, 1 bit: job start pulse, sampled only in IDLE.
REQ-008 Port cfg_num_pix, input, $clog2(DEPTH)+1 bits: pixels per pass, 1..DEPTH.
REQ-009 Port cfg_num_pass, input, 4 bits: accumulation passes, 1..15.
REQ-010 Port cfg_shift, input, 4 bits: arithmetic right-shift amount for requantization.
REQ-011 Port cfg_relu, input, 1 bit: enables ReLU before clamping.
REQ-012 Port psum_valid, input, 1 bit: psum_in carries a valid partial sum this cycle.
REQ-013 Port psum_in, input, PSUM_WIDTH bits, signed: partial sum from the last PE of the column.
REQ-014 Port ofm_valid, output, 1 bit: ofm_data is valid.
REQ-015 Port ofm_ready, input, 1 bit: downstream accepts ofm_data.
REQ-016 Port ofm_data, output, OFM_WIDTH bits, signed: requantized output value.
REQ-017 Port busy, output, 1 bit: high in every state except IDLE.
REQ-018 Port done, output, 1 bit: one-cycle pulse after the last output beat is accepted.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM, DRAIN and DONE.
REQ-020 IDLE with cfg_start=1 SHALL latch all cfg_* inputs, clear pix_cnt, pass_cnt and rd_ptr, and enter ACCUM on the next edge.
REQ-021 A cfg_num_pix or cfg_num_pass value of 0 SHALL be latched as 1, and a cfg_num_pix value above DEPTH SHALL be latched as DEPTH.
REQ-022 In ACCUM, each psum_valid cycle SHALL write acc[pix_cnt] = sext(psum_in) when pass_cnt==0, else acc[pix_cnt] + sext(psum_in).
REQ-023 pix_cnt SHALL increment per accepted psum and wrap to 0 after num_pix-1, incrementing pass_cnt at the wrap.
REQ-024 The wrap at pass_cnt==num_pass-1 SHALL move the FSM to DRAIN on the same edge as the final accumulator write.
REQ-025 psum_valid SHALL be ignored outside ACCUM, and cfg_start SHALL be ignored outside IDLE.
REQ-026 Accumulation SHALL use two's-complement wrap with no saturation; ACC_WIDTH >= PSUM_WIDTH+4 is guaranteed and no overflow can occur.
REQ-027 ofm_data SHALL be registered and equal clamp(relu(acc[rd_ptr] >>> shift)), using floor shift and no rounding.
REQ-028 When relu=1, negative values SHALL become 0 before clamping.
REQ-029 The clamp range SHALL be [-2^(OFM_WIDTH-1), 2^(OFM_WIDTH-1)-1].
REQ-030 The first ofm_valid SHALL assert in the first DRAIN cycle, one cycle after the final psum is accepted.
REQ-031 While ofm_valid=1 and ofm_ready=0, ofm_valid and ofm_data SHALL hold stable.
REQ-032 On ofm_valid && ofm_ready, rd_ptr SHALL advance and the next beat SHALL be presented in the following cycle, sustaining 1 beat/cycle.
REQ-033 Acceptance of beat num_pix-1 SHALL deassert ofm_valid and enter DONE.
REQ-034 DONE SHALL assert done for exactly one cycle and then return to IDLE.

Reset
REQ-035 rst_n=0 SHALL asynchronously force state IDLE, all counters to 0, and ofm_valid, ofm_data, busy and done to 0.
REQ-036 Reset mid-job SHALL abandon the job; accumulator contents are don't-care after reset.

Structure
REQ-037 FSM state encodings and default parameter constants SHALL reside in the shared package cnn_pkg.
REQ-038 Shift, ReLU and clamp SHALL be implemented in the combinational sub-module requant_unit, instantiated once.

Verification
REQ-039 Start with num_pix=4, num_pass=1, shift=0, relu=0 and psums 5,-3,200,-200 -> ofm 5,-3,127,-128, followed by a done pulse.
REQ-040 Start with num_pix=2, num_pass=3, shift=2 and psums 10,-10 each pass -> acc 30,-30 -> ofm 7,-8.
REQ-041 Set relu=1 and feed psum -50 on one pixel -> ofm 0.
REQ-042 Hold ofm_ready=0 for 5 cycles mid-drain -> ofm_valid and ofm_data stay stable, with no beat lost or duplicated.
REQ-043 Pulse cfg_start and psum_valid during DRAIN -> both are ignored and the output sequence is unchanged.
REQ-044 Assert rst_n=0 during ACCUM -> busy=0 and ofm_valid=0 immediately; a new job then runs correctly.

Source files
------------

// File: rtl/psum_collector_pkg.sv
// Shared constants and FSM encoding for the partial-sum collector and its
// requantization datapath.
package cnn_pkg;

  localparam int DEF_PSUM_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_OFM_WIDTH  = 8;
  localparam int DEF_DEPTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/psum_collector_if.sv
// Streaming bus between a PE column, the collector and the output consumer.
interface psum_collector_if import cnn_pkg::*; #(
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter int OFM_WIDTH  = DEF_OFM_WIDTH
);

  logic                         psum_valid;
  logic signed [PSUM_WIDTH-1:0] psum_in;
  logic                         ofm_valid;
  logic                         ofm_ready;
  logic signed [OFM_WIDTH-1:0]  ofm_data;

  modport master (
    output psum_valid, psum_in, ofm_ready,
    input  ofm_valid, ofm_data
  );

  modport slave (
    input  psum_valid, psum_in, ofm_ready,
    output ofm_valid, ofm_data
  );

endinterface

// File: rtl/psum_collector_requant_unit.sv
// Combinational requantizer: floor arithmetic shift, optional ReLU, then
// saturation to the signed output range.
module requant_unit import cnn_pkg::*; #(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OFM_WIDTH = DEF_OFM_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  input  logic        [3:0]           shift,
  input  logic                        relu,
  output logic signed [OFM_WIDTH-1:0] ofm_out
);

  localparam logic signed [ACC_WIDTH-1:0] OFM_MAX = ACC_WIDTH'((1 << (OFM_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OFM_MIN = ~OFM_MAX;

  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] rectified;

  always_comb begin
    shifted   = acc_in >>> shift;
    rectified = (relu && shifted[ACC_WIDTH-1]) ? '0 : shifted;
    if (rectified > OFM_MAX) begin
      ofm_out = OFM_WIDTH'(OFM_MAX);
    end else if (rectified < OFM_MIN) begin
      ofm_out = OFM_WIDTH'(OFM_MIN);
    end else begin
      ofm_out = OFM_WIDTH'(rectified);
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates partial sums over several passes per output pixel, then drains
// the requantized results as a ready/valid stream.
module psum_collector import cnn_pkg::*; #(
  parameter  int PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter  int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter  int OFM_WIDTH  = DEF_OFM_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int PIX_W      = $clog2(DEPTH) + 1,
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [PIX_W-1:0] cfg_num_pix,
  input  logic [3:0]       cfg_num_pass,
  input  logic [3:0]       cfg_shift,
  input  logic             cfg_relu,
  psum_collector_if.slave  bus,
  output logic             busy,
  output logic             done
);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            pix_cnt_q, pix_cnt_d;
  logic [IDX_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [3:0]                  pass_cnt_q, pass_cnt_d;
  logic [PIX_W-1:0]            num_pix_q, num_pix_d;
  logic [3:0]                  num_pass_q, num_pass_d;
  logic [3:0]                  shift_q, shift_d;
  logic                        relu_q, relu_d;
  logic                        ofm_valid_q, ofm_valid_d;
  logic signed [OFM_WIDTH-1:0] ofm_data_q, ofm_data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic signed [ACC_WIDTH-1:0] acc_q [DEPTH];
  logic signed [ACC_WIDTH-1:0] acc_d [DEPTH];

  logic signed [ACC_WIDTH-1:0] psum_ext;
  logic signed [ACC_WIDTH-1:0] rq_in;
  logic signed [OFM_WIDTH-1:0] rq_out;
  logic                        load_out;
  logic                        last_pix, last_pass, last_beat;

  assign psum_ext  = ACC_WIDTH'(bus.psum_in);
  assign last_pix  = (PIX_W'(pix_cnt_q) == num_pix_q - PIX_W'(1));
  assign last_pass = (pass_cnt_q == num_pass_q - 4'd1);
  assign last_beat = (PIX_W'(rd_ptr_q) == num_pix_q - PIX_W'(1));

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    pass_cnt_d  = pass_cnt_q;
    num_pix_d   = num_pix_q;
    num_pass_d  = num_pass_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    ofm_valid_d = ofm_valid_q;
    acc_d       = acc_q;
    load_out    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_num_pix == '0) begin
            num_pix_d = PIX_W'(1);
          end else if (cfg_num_pix > PIX_W'(DEPTH)) begin
            num_pix_d = PIX_W'(DEPTH);
          end else begin
            num_pix_d = cfg_num_pix;
          end
          num_pass_d = (cfg_num_pass == 4'd0) ? 4'd1 : cfg_num_pass;
          shift_d    = cfg_shift;
          relu_d     = cfg_relu;
          pix_cnt_d  = '0;
          pass_cnt_d = '0;
          rd_ptr_d   = '0;
          state_d    = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (bus.psum_valid) begin
          acc_d[pix_cnt_q] = (pass_cnt_q == 4'd0) ? psum_ext : acc_q[pix_cnt_q] + psum_ext;
          if (last_pix) begin
            pix_cnt_d = '0;
            // The first beat is sourced from acc_d so it reflects this cycle's final write.
            if (last_pass) begin
              state_d     = ST_DRAIN;
              rd_ptr_d    = '0;
              ofm_valid_d = 1'b1;
              load_out    = 1'b1;
            end else begin
              pass_cnt_d = pass_cnt_q + 4'd1;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + IDX_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (ofm_valid_q && bus.ofm_ready) begin
          if (last_beat) begin
            ofm_valid_d = 1'b0;
            state_d     = ST_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + IDX_W'(1);
            load_out = 1'b1;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign rq_in      = acc_d[rd_ptr_d];
  assign ofm_data_d = load_out ? rq_out : ofm_data_q;

  requant_unit #(
    .ACC_WIDTH (ACC_WIDTH),
    .OFM_WIDTH (OFM_WIDTH)
  ) u_requant (
    .acc_in  (rq_in),
    .shift   (shift_q),
    .relu    (relu_q),
    .ofm_out (rq_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      rd_ptr_q    <= '0;
      pass_cnt_q  <= '0;
      num_pix_q   <= PIX_W'(1);
      num_pass_q  <= 4'd1;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      ofm_valid_q <= 1'b0;
      ofm_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      pass_cnt_q  <= pass_cnt_d;
      num_pix_q   <= num_pix_d;
      num_pass_q  <= num_pass_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      ofm_valid_q <= ofm_valid_d;
      ofm_data_q  <= ofm_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Accumulator contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign bus.ofm_valid = ofm_valid_q;
  assign bus.ofm_data  = ofm_data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: expected beats are queued when the
// partial sums are driven and popped as the collector drains them.
module tb_psum_collector;
  import cnn_pkg::*;

  localparam int PSUM_W = 16;
  localparam int OFM_W  = 8;
  localparam int DEPTH  = 16;
  localparam int OFM_HI = (1 << (OFM_W - 1)) - 1;
  localparam int OFM_LO = -(1 << (OFM_W - 1));

  logic       clk;
  logic       rst_n;
  logic       cfg_start;
  logic [4:0] cfg_num_pix;
  logic [3:0] cfg_num_pass;
  logic [3:0] cfg_shift;
  logic       cfg_relu;
  logic       busy;
  logic       done;

  psum_collector_if #(.PSUM_WIDTH(PSUM_W), .OFM_WIDTH(OFM_W)) bus ();

  psum_collector #(
    .PSUM_WIDTH (PSUM_W),
    .ACC_WIDTH  (24),
    .OFM_WIDTH  (OFM_W),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_num_pix  (cfg_num_pix),
    .cfg_num_pass (cfg_num_pass),
    .cfg_shift    (cfg_shift),
    .cfg_relu     (cfg_relu),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  int     checks = 0;
  int     errors = 0;
  int     exp_q[$];
  int     psum_tab[256];
  longint acc_m[DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int modelRequant(input longint a, input int sh, input bit relu);
    longint v;
    v = a >>> sh;
    if (relu && v < 0) v = 0;
    if (v > OFM_HI) v = OFM_HI;
    else if (v < OFM_LO) v = OFM_LO;
    return int'(v);
  endfunction

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) psum_tab[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  // Runs one complete job: configure, stream psums, drain with optional stall
  // and stray-input injection, then check the done pulse.
  task automatic applyStimulus(input int num_pix_cfg, input int num_pass_cfg, input int shift_cfg,
                               input bit relu_cfg, input int stall_at, input bit inject);
    int np, npass, total, idx, beats, cyc, stall_cnt, held, exp_v, done_cnt;
    bit first, prev_stall;
    np    = (num_pix_cfg == 0) ? 1 : ((num_pix_cfg > DEPTH) ? DEPTH : num_pix_cfg);
    npass = (num_pass_cfg == 0) ? 1 : num_pass_cfg;
    total = np * npass;

    @(posedge clk); #1;
    cfg_num_pix  = 5'(num_pix_cfg);
    cfg_num_pass = 4'(num_pass_cfg);
    cfg_shift    = 4'(shift_cfg);
    cfg_relu     = relu_cfg;
    cfg_start    = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;

    for (int k = 0; k < total; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.psum_valid = 1'b0;
        bus.psum_in    = PSUM_W'($urandom);
        @(posedge clk); #1;
      end
      idx = k % np;
      acc_m[idx] = (k < np) ? longint'(psum_tab[k]) : acc_m[idx] + longint'(psum_tab[k]);
      bus.psum_valid = 1'b1;
      bus.psum_in    = PSUM_W'(psum_tab[k]);
      if (k == total - 1) begin
        for (int i = 0; i < np; i++) exp_q.push_back(modelRequant(acc_m[i], shift_cfg, relu_cfg));
        @(negedge clk);
        checkOutput("valid_before_last_psum", int'(bus.ofm_valid), 0);
      end
      @(posedge clk); #1;
      bus.psum_valid = 1'b0;
    end

    beats = 0; cyc = 0; stall_cnt = 0; held = 0; first = 1'b1; prev_stall = 1'b0;
    while (beats < np && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (first) begin
        checkOutput("first_beat_valid", int'(bus.ofm_valid), 1);
        checkOutput("busy_in_drain", int'(busy), 1);
        first = 1'b0;
      end
      if (prev_stall) begin
        checkOutput("hold_valid", int'(bus.ofm_valid), 1);
        checkOutput("hold_data", int'(bus.ofm_data), held);
      end
      if (bus.ofm_valid && bus.ofm_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", int'(bus.ofm_data), -9999);
        end else begin
          exp_v = exp_q.pop_front();
          checkOutput("ofm_data", int'(bus.ofm_data), exp_v);
        end
        beats++;
        prev_stall = 1'b0;
      end else if (bus.ofm_valid) begin
        held       = int'(bus.ofm_data);
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk); #1;
      if (beats == stall_at && stall_cnt < 5) begin
        bus.ofm_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.ofm_ready = 1'b1;
      end
      if (inject && cyc == 2) begin
        cfg_start      = 1'b1;
        bus.psum_valid = 1'b1;
        bus.psum_in    = 16'sd77;
      end else begin
        cfg_start      = 1'b0;
        bus.psum_valid = 1'b0;
      end
    end
    cfg_start      = 1'b0;
    bus.psum_valid = 1'b0;
    bus.ofm_ready  = 1'b1;
    if (beats < np) checkOutput("drain_timeout", beats, np);

    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("valid_after_last_beat", int'(bus.ofm_valid), 0);
      if (done) done_cnt++;
    end
    checkOutput("done_pulse_count", done_cnt, 1);
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("scoreboard_left", exp_q.size(), 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    cfg_start      = 1'b0;
    cfg_num_pix    = '0;
    cfg_num_pass   = '0;
    cfg_shift      = '0;
    cfg_relu       = 1'b0;
    bus.psum_valid = 1'b0;
    bus.psum_in    = '0;
    bus.ofm_ready  = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_valid", int'(bus.ofm_valid), 0);
    checkOutput("reset_data", int'(bus.ofm_data), 0);
    #2 rst_n = 1'b1;

    // Saturation at both ends of the output range.
    psum_tab[0] = 5; psum_tab[1] = -3; psum_tab[2] = 200; psum_tab[3] = -200;
    applyStimulus(4, 1, 0, 0, -1, 0);

    // Three-pass accumulation with floor shift.
    for (int i = 0; i < 6; i++) psum_tab[i] = (i % 2 == 0) ? 10 : -10;
    applyStimulus(2, 3, 2, 0, -1, 0);

    // ReLU on a single pixel, requested as zero pixels.
    psum_tab[0] = -50;
    applyStimulus(0, 1, 0, 1, -1, 0);

    // Backpressure mid-drain plus stray start/psum pulses.
    fillRandom(8);
    applyStimulus(4, 2, 1, 0, 2, 1);

    // Oversized pixel request clips to the full depth.
    fillRandom(DEPTH);
    applyStimulus(31, 1, 3, 1, -1, 0);

    // Abandon a job partway through accumulation.
    @(posedge clk); #1;
    cfg_num_pix = 5'd4; cfg_num_pass = 4'd2; cfg_shift = 4'd0; cfg_relu = 1'b0;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.psum_valid = 1'b1;
      bus.psum_in    = 16'sd1000;
      @(posedge clk); #1;
    end
    bus.psum_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy_in_accum", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("busy_async_reset", int'(busy), 0);
    checkOutput("valid_async_reset", int'(bus.ofm_valid), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Fresh jobs after reset: zero passes means one, and the full 15 passes.
    fillRandom(5);
    applyStimulus(5, 0, 4, 0, -1, 0);
    fillRandom(45);
    applyStimulus(3, 15, 6, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
